// File: rtl/keypad_digit_entry.sv
// keypad_digit_entry
//   Debounces a one-hot 16-key keypad scan and decodes each accepted press
//   into a digit (0..9) or a function code (CLEAR 0xC, BACKSPACE 0xB,
//   ENTER 0xE). Digits are assembled into a BCD register of DIGITS nibbles.
//
// Parameters
//   DIGITS     number of BCD digits held (1..8)
//   DEB_CYCLES identical consecutive samples needed to accept a key state
//   SHIFT_MODE 0 = positional entry, 1 = calculator-style shift entry
//   CNT_W      width of o_digit_count (2**CNT_W > DIGITS)
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   i_onehot       raw keypad scan, one bit per key
//   o_digits       BCD digit register, nibble k = digit k
//   o_digit_count  number of digits entered, 0..DIGITS
//   o_full         high when o_digit_count == DIGITS
//   o_key_pulse    one-cycle strobe on every accepted press
//   o_key_code     code of the last accepted press (held)
//   o_enter_pulse  one-cycle strobe when ENTER is accepted
module keypad_digit_entry #(
  parameter int DIGITS     = 3,
  parameter int DEB_CYCLES = 4,
  parameter int SHIFT_MODE = 0,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           i_onehot,
  output logic [4*DIGITS-1:0]   o_digits,
  output logic [CNT_W-1:0]      o_digit_count,
  output logic                  o_full,
  output logic                  o_key_pulse,
  output logic [3:0]            o_key_code,
  output logic                  o_enter_pulse
);

  localparam logic [3:0]  C_REL   = 4'hF;
  localparam logic [3:0]  C_CLR   = 4'hC;
  localparam logic [3:0]  C_BS    = 4'hB;
  localparam logic [3:0]  C_ENT   = 4'hE;
  localparam logic [15:0] DEB_MAX = 16'(DEB_CYCLES);
  localparam logic [15:0] DEB_THR = 16'(DEB_CYCLES - 1);

  logic [3:0]              w_raw;
  logic [3:0]              r_sample;
  logic [15:0]             r_cnt;
  logic [3:0]              r_stable;
  logic                    r_armed;
  logic                    w_upd;
  logic                    w_press;
  logic [4*DIGITS-1:0]     r_digits;
  logic [CNT_W-1:0]        r_count;
  logic [4*DIGITS-1:0]     w_dig_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [CNT_W-1:0]        w_last_idx;
  logic                    w_full;

  // Raw key decode; anything that is not exactly one mapped key is RELEASED.
  always_comb begin
    case (i_onehot)
      16'h0008: w_raw = 4'd0;
      16'h0080: w_raw = 4'd1;
      16'h0040: w_raw = 4'd2;
      16'h0020: w_raw = 4'd3;
      16'h0800: w_raw = 4'd4;
      16'h0400: w_raw = 4'd5;
      16'h0200: w_raw = 4'd6;
      16'h8000: w_raw = 4'd7;
      16'h4000: w_raw = 4'd8;
      16'h2000: w_raw = 4'd9;
      16'h0001: w_raw = C_CLR;
      16'h0002: w_raw = C_BS;
      16'h0004: w_raw = C_ENT;
      default:  w_raw = C_REL;
    endcase
  end

  // r_cnt holds (run length of r_sample) - 1, so the sample has been steady
  // for DEB_CYCLES cycles once it reaches DEB_CYCLES-1.
  assign w_upd = (r_cnt >= DEB_THR);

  // A press needs a RELEASED->key transition of the stable code, and the arm
  // flag, which is only set once a debounced RELEASED has been observed after
  // reset; this rejects a key that was held through reset deassertion.
  assign w_press = w_upd && r_armed && (r_stable == C_REL) && (r_sample != C_REL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample <= C_REL;
      r_cnt    <= '0;
      r_stable <= C_REL;
      r_armed  <= 1'b0;
    end else begin
      r_sample <= w_raw;
      if (w_raw != r_sample) begin
        r_cnt <= '0;
      end else if (r_cnt != DEB_MAX) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_upd) begin
        r_stable <= r_sample;
        if (r_sample == C_REL) begin
          r_armed <= 1'b1;
        end
      end
    end
  end

  assign w_full     = (r_count == CNT_W'(DIGITS));
  assign w_last_idx = r_count - CNT_W'(1);

  // Next digit register / count for the accepted key.
  always_comb begin
    w_dig_nxt = r_digits;
    w_cnt_nxt = r_count;
    if (w_press) begin
      if (r_sample <= 4'd9) begin
        if (!w_full) begin
          if (SHIFT_MODE == 0) begin
            for (int k = 0; k < DIGITS; k++) begin
              if (CNT_W'(k) == r_count) begin
                w_dig_nxt[4*k +: 4] = r_sample;
              end
            end
          end else begin
            // Not full, so the top nibble is zero and nothing is lost.
            for (int k = DIGITS - 1; k > 0; k--) begin
              w_dig_nxt[4*k +: 4] = r_digits[4*(k-1) +: 4];
            end
            w_dig_nxt[3:0] = r_sample;
          end
          w_cnt_nxt = r_count + CNT_W'(1);
        end
      end else if (r_sample == C_BS) begin
        if (r_count != '0) begin
          if (SHIFT_MODE == 0) begin
            for (int k = 0; k < DIGITS; k++) begin
              if (CNT_W'(k) == w_last_idx) begin
                w_dig_nxt[4*k +: 4] = 4'd0;
              end
            end
          end else begin
            for (int k = 0; k < DIGITS - 1; k++) begin
              w_dig_nxt[4*k +: 4] = r_digits[4*(k+1) +: 4];
            end
            w_dig_nxt[4*(DIGITS-1) +: 4] = 4'd0;
          end
          w_cnt_nxt = w_last_idx;
        end
      end else if (r_sample == C_CLR) begin
        w_dig_nxt = '0;
        w_cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits      <= '0;
      r_count       <= '0;
      o_key_code    <= C_REL;
      o_key_pulse   <= 1'b0;
      o_enter_pulse <= 1'b0;
    end else begin
      r_digits      <= w_dig_nxt;
      r_count       <= w_cnt_nxt;
      o_key_pulse   <= w_press;
      o_enter_pulse <= w_press && (r_sample == C_ENT);
      if (w_press) begin
        o_key_code <= r_sample;
      end
    end
  end

  assign o_digits      = r_digits;
  assign o_digit_count = r_count;
  assign o_full        = w_full;

endmodule

// File: tb/tb_keypad_digit_entry.sv
module tb_keypad_digit_entry;
  localparam int DIGITS = 3;
  localparam int DEB    = 4;
  localparam int CNT_W  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] onehot = 16'h0;

  logic [11:0] dig0, dig1;
  logic [3:0]  cnt0, cnt1, code0, code1;
  logic        full0, full1, kp0, kp1, ep0, ep1;

  keypad_digit_entry #(.DIGITS(DIGITS), .DEB_CYCLES(DEB), .SHIFT_MODE(0), .CNT_W(CNT_W)) u0 (
    .clk(clk), .rst_n(rst_n), .i_onehot(onehot), .o_digits(dig0), .o_digit_count(cnt0),
    .o_full(full0), .o_key_pulse(kp0), .o_key_code(code0), .o_enter_pulse(ep0));

  keypad_digit_entry #(.DIGITS(DIGITS), .DEB_CYCLES(DEB), .SHIFT_MODE(1), .CNT_W(CNT_W)) u1 (
    .clk(clk), .rst_n(rst_n), .i_onehot(onehot), .o_digits(dig1), .o_digit_count(cnt1),
    .o_full(full1), .o_key_pulse(kp1), .o_key_code(code1), .o_enter_pulse(ep1));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pc0 = 0;
  int ec0 = 0;
  int last_pulse_cyc = -100;
  logic [11:0] enter_dig0 = '0;
  logic [3:0]  enter_cnt0 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic logic [3:0] ref_code(input logic [15:0] v);
    int b;
    b = -1;
    if ($countones(v) != 1) return 4'hF;
    for (int i = 0; i < 16; i++) if (v[i]) b = i;
    case (b)
      3: return 4'd0;   7: return 4'd1;   6: return 4'd2;   5: return 4'd3;
      11: return 4'd4;  10: return 4'd5;  9: return 4'd6;   15: return 4'd7;
      14: return 4'd8;  13: return 4'd9;
      0: return 4'hC;   1: return 4'hB;   2: return 4'hE;
      default: return 4'hF;
    endcase
  endfunction

  logic [3:0] m_hist[$];
  logic [3:0] m_entered[$];
  logic [3:0] m_stable = 4'hF;
  logic       m_armed = 1'b0;
  logic [3:0] m_code = 4'hF;
  logic       m_pulse = 1'b0;
  logic       m_enter = 1'b0;

  function automatic logic [11:0] exp_digits(input int mode);
    logic [11:0] r;
    int n;
    r = '0;
    n = m_entered.size();
    for (int k = 0; k < n; k++) begin
      if (mode == 0) r[4*k +: 4] = m_entered[k];
      else           r[4*k +: 4] = m_entered[n-1-k];
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hist.delete();
      m_hist.push_back(4'hF);
      m_entered.delete();
      m_stable = 4'hF;
      m_armed  = 1'b0;
      m_code   = 4'hF;
      m_pulse  = 1'b0;
      m_enter  = 1'b0;
    end else begin
      logic same;
      logic [3:0] nv;
      m_pulse = 1'b0;
      m_enter = 1'b0;
      same = (m_hist.size() == DEB);
      for (int i = 1; i < m_hist.size(); i++) if (m_hist[i] != m_hist[0]) same = 1'b0;
      if (same) begin
        nv = m_hist[m_hist.size()-1];
        if (m_stable == 4'hF && nv != 4'hF && m_armed) begin
          m_code  = nv;
          m_pulse = 1'b1;
          if (nv <= 4'd9) begin
            if (m_entered.size() < DIGITS) m_entered.push_back(nv);
          end else if (nv == 4'hB) begin
            if (m_entered.size() > 0) void'(m_entered.pop_back());
          end else if (nv == 4'hC) begin
            m_entered.delete();
          end else if (nv == 4'hE) begin
            m_enter = 1'b1;
          end
        end
        if (nv == 4'hF) m_armed = 1'b1;
        m_stable = nv;
      end
      m_hist.push_back(ref_code(onehot));
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("digits_m0", 32'(dig0), 32'(exp_digits(0)));
      chk("digits_m1", 32'(dig1), 32'(exp_digits(1)));
      chk("count_m0",  32'(cnt0), 32'(m_entered.size()));
      chk("count_m1",  32'(cnt1), 32'(m_entered.size()));
      chk("full_m0",   32'(full0), 32'(m_entered.size() == DIGITS));
      chk("full_m1",   32'(full1), 32'(m_entered.size() == DIGITS));
      chk("pulse_m0",  32'(kp0), 32'(m_pulse));
      chk("pulse_m1",  32'(kp1), 32'(m_pulse));
      chk("code_m0",   32'(code0), 32'(m_code));
      chk("code_m1",   32'(code1), 32'(m_code));
      chk("enter_m0",  32'(ep0), 32'(m_enter));
      chk("enter_m1",  32'(ep1), 32'(m_enter));
    end
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (kp0) begin
      pc0++;
      last_pulse_cyc = cyc;
    end
    if (ep0) begin
      ec0++;
      enter_dig0 = dig0;
      enter_cnt0 = cnt0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic press(input logic [15:0] v, input int hold, input int gap, input logic chk_lat);
    int t0;
    @(posedge clk);
    #1 onehot = v;
    t0 = cyc;
    repeat (hold) @(posedge clk);
    #1 onehot = 16'h0;
    repeat (gap) @(posedge clk);
    #1;
    if (chk_lat) chk("latency", 32'(last_pulse_cyc - t0), 32'(DEB + 1));
  endtask

  initial begin
    int p;
    int e;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digits", 32'(dig0), 32'h0);
    chk("rst_count",  32'(cnt0), 32'h0);
    chk("rst_full",   32'(full0), 32'h0);
    chk("rst_code",   32'(code0), 32'hF);
    chk("rst_pulse",  32'(kp0), 32'h0);
    chk("rst_enter",  32'(ep0), 32'h0);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);

    // keys 1,2,3
    p = pc0;
    press(16'h0080, 8, 8, 1'b1);
    press(16'h0040, 8, 8, 1'b1);
    press(16'h0020, 8, 8, 1'b1);
    chk("m0_321", 32'(dig0), 32'h321);
    chk("m1_123", 32'(dig1), 32'h123);
    chk("cnt_3",  32'(cnt0), 32'd3);
    chk("full_3", 32'(full0), 32'd1);
    chk("pulses_3", 32'(pc0 - p), 32'd3);

    // full + key 8
    p = pc0;
    press(16'h4000, 8, 8, 1'b0);
    chk("full_hold", 32'(dig0), 32'h321);
    chk("code_8",    32'(code0), 32'h8);
    chk("pulse_full", 32'(pc0 - p), 32'd1);

    // backspace, clear
    press(16'h0002, 8, 8, 1'b0);
    chk("bs_m0", 32'(dig0), 32'h021);
    chk("bs_m1", 32'(dig1), 32'h012);
    chk("bs_cnt", 32'(cnt1), 32'd2);
    press(16'h0001, 8, 8, 1'b0);
    chk("clr_dig",  32'(dig0), 32'h0);
    chk("clr_full", 32'(full0), 32'h0);

    // bounce then long hold
    p = pc0;
    for (int i = 0; i < 6; i++) press(16'h0008, 3, 3, 1'b0);
    repeat (8) @(posedge clk);
    #1 chk("bounce", 32'(pc0 - p), 32'd0);
    press(16'h0008, 200, 8, 1'b0);
    chk("long_hold", 32'(pc0 - p), 32'd1);
    chk("long_cnt",  32'(cnt0), 32'd1);

    // key-to-key change without release
    press(16'h0001, 8, 8, 1'b0);
    p = pc0;
    @(posedge clk);
    #1 onehot = 16'h0080;
    repeat (8) @(posedge clk);
    #1 onehot = 16'h0040;
    repeat (8) @(posedge clk);
    #1 onehot = 16'h0;
    repeat (8) @(posedge clk);
    #1;
    chk("k2k_pulses", 32'(pc0 - p), 32'd1);
    chk("k2k_code",   32'(code0), 32'h1);
    chk("k2k_dig",    32'(dig0), 32'h001);

    // enter after 5,6
    press(16'h0001, 8, 8, 1'b0);
    press(16'h0400, 8, 8, 1'b0);
    press(16'h0200, 8, 8, 1'b0);
    e = ec0;
    press(16'h0004, 8, 8, 1'b0);
    chk("enter_cnt", 32'(ec0 - e), 32'd1);
    chk("enter_dig", 32'(enter_dig0), 32'h065);
    chk("enter_n",   32'(enter_cnt0), 32'd2);

    // reset while a key is held
    press(16'h0001, 8, 8, 1'b0);
    @(posedge clk);
    #1 onehot = 16'h0800;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    p = pc0;
    repeat (20) @(posedge clk);
    #1 onehot = 16'h0;
    chk("rst_held_pulse", 32'(pc0 - p), 32'd0);
    chk("rst_held_dig",   32'(dig0), 32'h0);
    repeat (10) @(posedge clk);
    press(16'h0800, 8, 8, 1'b0);
    chk("repress_m0", 32'(dig0), 32'h004);
    chk("repress_m1", 32'(dig1), 32'h004);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [15:0] v;
      r = $urandom_range(0, 19);
      if (r < 16)       v = 16'(1 << r);
      else if (r == 16) v = 16'h0;
      else              v = 16'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
      end
      press(v, $urandom_range(1, 9), $urandom_range(0, 8), 1'b0);
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
